map_select_ctrl: RTL and testbench

Parametrised mapper-selection controller for the cart FPGA, the next generation of the mapper mux control path. It runs in the `clk` domain and does several jobs. It synchronises `m2` and the MCU register-write toggle. It decodes mapper/launcher/CHR configuration writes. It detects interrupt-vector fetches that switch between launcher (mapper 0) and game mapper. It generates the CPU-reset watchdog and the per-mapper reset vector for up to `MAP_CNT` mappers, and rejects out-of-range mapper IDs.

---
 rtl/map_select_ctrl_if.sv | 18 +
 rtl/map_select_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_map_select_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_select_ctrl_if.sv
// CPU bus and MCU register-write signals shared between the cart logic and
// the mapper-selection controller. The master side drives, the slave samples.
interface map_select_ctrl_if;
   logic        m2;
   logic [15:0] cpu_addr;
   logic        cpu_rw;
   logic [15:0] wr_reg;
   logic [3:0]  wr_reg_addr;
   logic        wr_reg_changed;

   modport master (
      output m2, cpu_addr, cpu_rw, wr_reg, wr_reg_addr, wr_reg_changed
   );

   modport slave (
      input m2, cpu_addr, cpu_rw, wr_reg, wr_reg_addr, wr_reg_changed
   );
endinterface

// File: rtl/map_select_ctrl.sv
// Mapper-selection controller: synchronises M2 and the MCU write toggle,
// decodes configuration writes, switches between launcher and game mapper on
// interrupt-vector fetches, and runs the CPU-reset watchdog.
module map_select_ctrl #(
   parameter int  MAP_CNT      = 8,
   parameter int  ADDR_BITS    = 23,
   parameter int  RESET_CYCLES = 255,
   localparam int MAP_BITS     = $clog2(MAP_CNT)
) (
   input  logic                 clk,
   input  logic                 reset,
   map_select_ctrl_if.slave     bus,
   output logic [MAP_BITS-1:0]  select_o,
   output logic [MAP_BITS-1:0]  game_select_o,
   output logic [MAP_CNT-1:0]   mapper_reset_o,
   output logic [4:0]           map_args_o,
   output logic [ADDR_BITS-1:0] prg_mask_o,
   output logic [ADDR_BITS-1:0] chr_base_o,
   output logic [ADDR_BITS-1:0] chr_mask_o,
   output logic [3:0]           launcher_ctrl_o,
   output logic                 cpu_reset_o,
   output logic                 cfg_error_o,
   output logic [7:0]           switch_cnt_o
);

   localparam int                   IDLE_BITS   = $clog2(RESET_CYCLES + 1);
   localparam logic [IDLE_BITS-1:0] IDLE_MAX    = IDLE_BITS'(RESET_CYCLES);
   localparam logic [15:0]          VEC_RST     = 16'hFFFC;
   localparam logic [15:0]          VEC_NMI     = 16'hFFFA;
   localparam logic [15:0]          VEC_MENU    = 16'hFFFB;
   localparam logic [15:0]          VEC_RESTORE = 16'hFFEB;

   // launcher_ctrl bit positions
   localparam int LB_START   = 1;
   localparam int LB_RESTORE = 2;
   localparam int LB_MENU    = 3;

   // (1<<lg)-1, saturating to all ones once the shift leaves the address space
   function automatic logic [ADDR_BITS-1:0] lowMask(input logic [4:0] lg);
      logic [ADDR_BITS-1:0] m;
      if (32'(lg) >= 32'(ADDR_BITS)) m = '1;
      else                           m = (ADDR_BITS'(1) << lg) - ADDR_BITS'(1);
      return m;
   endfunction

   // 1<<lg, or zero once the bit would fall outside the address space
   function automatic logic [ADDR_BITS-1:0] bitAt(input logic [4:0] lg);
      logic [ADDR_BITS-1:0] b;
      if (32'(lg) >= 32'(ADDR_BITS)) b = '0;
      else                           b = ADDR_BITS'(1) << lg;
      return b;
   endfunction

   logic m2Meta_q, m2Sync_q, m2Prev_q;
   logic wrMeta_q, wrSync_q, wrPrev_q;
   logic [15:0] addr_q;
   logic        rw_q;

   logic [MAP_BITS-1:0]  select_q, select_d;
   logic [MAP_BITS-1:0]  game_q, game_d;
   logic [4:0]           args_q, args_d;
   logic [ADDR_BITS-1:0] prgMask_q, prgMask_d;
   logic [ADDR_BITS-1:0] chrBase_q, chrBase_d;
   logic [ADDR_BITS-1:0] chrMask_q, chrMask_d;
   logic [3:0]           launch_q, launch_d;
   logic                 cfgErr_q, cfgErr_d;
   logic [7:0]           switchCnt_q, switchCnt_d;
   logic [IDLE_BITS-1:0] idle_q, idle_d;
   logic                 cpuReset_q;

   logic       m2Fall, wrEvent, idBad;
   logic [4:0] wrId, wrPlog, wrArgs;
   logic       fallRst, fallNmi, fallMenu, fallRestore;
   logic       liveRst, liveNmi;

   assign m2Fall  = m2Prev_q & ~m2Sync_q;
   assign wrEvent = wrSync_q ^ wrPrev_q;
   assign wrId    = bus.wr_reg[4:0];
   assign wrPlog  = bus.wr_reg[9:5];
   assign wrArgs  = bus.wr_reg[14:10];
   assign idBad   = 32'(wrId) >= 32'(MAP_CNT);

   // Vector fetches as seen on the address captured while M2 was still high
   assign fallRst     = launch_q[LB_START]   & (addr_q == VEC_RST)     & rw_q;
   assign fallNmi     = launch_q[LB_MENU]    & (addr_q == VEC_NMI)     & rw_q;
   assign fallMenu    = launch_q[LB_MENU]    & (addr_q == VEC_MENU)    & rw_q;
   assign fallRestore = launch_q[LB_RESTORE] & (addr_q == VEC_RESTORE) & rw_q;

   // Live hijack terms so the vector fetch itself already sees the new mapper
   assign liveRst = launch_q[LB_START] & (bus.cpu_addr == VEC_RST) & bus.cpu_rw;
   assign liveNmi = launch_q[LB_MENU]  & (bus.cpu_addr == VEC_NMI) & bus.cpu_rw;

   // Synchronisers for M2 and the write toggle, plus the pre-fall address capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m2Meta_q <= 1'b0;
         m2Sync_q <= 1'b0;
         m2Prev_q <= 1'b0;
         wrMeta_q <= 1'b0;
         wrSync_q <= 1'b0;
         wrPrev_q <= 1'b0;
         addr_q   <= '0;
         rw_q     <= 1'b0;
      end else begin
         m2Meta_q <= bus.m2;
         m2Sync_q <= m2Meta_q;
         m2Prev_q <= m2Sync_q;
         wrMeta_q <= bus.wr_reg_changed;
         wrSync_q <= wrMeta_q;
         wrPrev_q <= wrSync_q;
         if (m2Sync_q) begin
            addr_q <= bus.cpu_addr;
            rw_q   <= bus.cpu_rw;
         end
      end
   end

   // Next-state for configuration, mapper selection, switch counter and watchdog
   always_comb begin
      select_d    = select_q;
      game_d      = game_q;
      args_d      = args_q;
      prgMask_d   = prgMask_q;
      chrBase_d   = chrBase_q;
      chrMask_d   = chrMask_q;
      launch_d    = launch_q;
      cfgErr_d    = cfgErr_q;
      switchCnt_d = switchCnt_q;
      idle_d      = idle_q;

      if (m2Fall) begin
         if (fallNmi)     select_d = '0;
         if (fallRst)     select_d = game_q;
         if (fallRestore) select_d = game_q;
      end

      if (wrEvent) begin
         case (bus.wr_reg_addr)
            4'd0: begin
               if (!cpuReset_q) begin
                  if (idBad) begin
                     cfgErr_d = 1'b1;
                  end else begin
                     game_d    = wrId[MAP_BITS-1:0];
                     args_d    = wrArgs;
                     prgMask_d = lowMask(wrPlog);
                     chrBase_d = bitAt(wrPlog);
                  end
               end
            end
            4'd1: begin
               if (!cpuReset_q) launch_d = bus.wr_reg[3:0];
            end
            4'd2: begin
               chrMask_d = lowMask(bus.wr_reg[4:0]);
               if (bus.wr_reg[15]) cfgErr_d = 1'b0;
            end
            default: ;
         endcase
      end

      // Bits consumed by a vector fetch win over a same-cycle launcher write
      if (m2Fall) begin
         if (fallRst)     launch_d[LB_START]   = 1'b0;
         if (fallMenu)    launch_d[LB_MENU]    = 1'b0;
         if (fallRestore) launch_d[LB_RESTORE] = 1'b0;
      end

      if (cpuReset_q) begin
         select_d  = '0;
         game_d    = '0;
         args_d    = '0;
         prgMask_d = '0;
         chrBase_d = '0;
         chrMask_d = '0;
         launch_d  = '0;
      end

      if (m2Fall && (select_d != select_q)) switchCnt_d = switchCnt_q + 8'd1;

      if (m2Fall)                  idle_d = '0;
      else if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_BITS'(1);
   end

   // Configuration and watchdog state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         select_q    <= '0;
         game_q      <= '0;
         args_q      <= '0;
         prgMask_q   <= '0;
         chrBase_q   <= '0;
         chrMask_q   <= '0;
         launch_q    <= '0;
         cfgErr_q    <= 1'b0;
         switchCnt_q <= '0;
         idle_q      <= '0;
         cpuReset_q  <= 1'b0;
      end else begin
         select_q    <= select_d;
         game_q      <= game_d;
         args_q      <= args_d;
         prgMask_q   <= prgMask_d;
         chrBase_q   <= chrBase_d;
         chrMask_q   <= chrMask_d;
         launch_q    <= launch_d;
         cfgErr_q    <= cfgErr_d;
         switchCnt_q <= switchCnt_d;
         idle_q      <= idle_d;
         cpuReset_q  <= (idle_q == IDLE_MAX);
      end
   end

   // Active mapper with the zero-latency hijack override, and per-slot resets
   always_comb begin
      if (liveRst)      select_o = game_q;
      else if (liveNmi) select_o = '0;
      else              select_o = select_q;
      mapper_reset_o = '0;
      for (int n = 0; n < MAP_CNT; n++) begin
         mapper_reset_o[n] = ((MAP_BITS'(n) != select_o) && (MAP_BITS'(n) != game_q)) || cpuReset_q;
      end
   end

   assign game_select_o   = game_q;
   assign map_args_o      = args_q;
   assign prg_mask_o      = prgMask_q;
   assign chr_base_o      = chrBase_q;
   assign chr_mask_o      = chrMask_q;
   assign launcher_ctrl_o = launch_q;
   assign cpu_reset_o     = cpuReset_q;
   assign cfg_error_o     = cfgErr_q;
   assign switch_cnt_o    = switchCnt_q;

endmodule

// File: tb/tb_map_select_ctrl.sv
// Self-checking bench for map_select_ctrl: a decode vector table, hand-written
// hijack/watchdog/reset sequences and a randomized phase, all compared against
// a transaction-level model of the mapper-selection rules.
module tb_map_select_ctrl;

   localparam int MAP_CNT      = 8;
   localparam int ADDR_BITS    = 23;
   localparam int RESET_CYCLES = 255;

   logic clk = 1'b0;
   logic reset;

   map_select_ctrl_if bus ();

   logic [2:0]  selectO, gameSelectO;
   logic [7:0]  mapperResetO;
   logic [4:0]  mapArgsO;
   logic [22:0] prgMaskO, chrBaseO, chrMaskO;
   logic [3:0]  launcherCtrlO;
   logic        cpuResetO, cfgErrorO;
   logic [7:0]  switchCntO;

   int errors = 0;
   int checks = 0;

   map_select_ctrl #(
      .MAP_CNT     (MAP_CNT),
      .ADDR_BITS   (ADDR_BITS),
      .RESET_CYCLES(RESET_CYCLES)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .select_o       (selectO),
      .game_select_o  (gameSelectO),
      .mapper_reset_o (mapperResetO),
      .map_args_o     (mapArgsO),
      .prg_mask_o     (prgMaskO),
      .chr_base_o     (chrBaseO),
      .chr_mask_o     (chrMaskO),
      .launcher_ctrl_o(launcherCtrlO),
      .cpu_reset_o    (cpuResetO),
      .cfg_error_o    (cfgErrorO),
      .switch_cnt_o   (switchCntO)
   );

   always #5 clk = ~clk;

   // Reference model state, updated once per transaction
   int          mSel, mGame, mSwitch, mIdle;
   logic [4:0]  mArgs;
   logic [22:0] mPrg, mChrBase, mChrMask;
   logic [3:0]  mLaunch;
   logic        mErr, mCpuRst;

   typedef struct packed {
      logic [3:0]  regAddr;
      logic [15:0] data;
      logic [2:0]  expGame;
      logic [22:0] expPrg;
      logic [22:0] expChrBase;
      logic [22:0] expChrMask;
      logic [4:0]  expArgs;
      logic        expErr;
      logic [7:0]  expMapRst;
   } vec_t;

   vec_t vecs [11];

   task automatic loadVectors();
      vecs[0]  = '{4'd0, 16'h0E43, 3'd3, 23'h03FFFF, 23'h040000, 23'h000000, 5'h03, 1'b0, 8'hF6};
      vecs[1]  = '{4'd0, 16'h00A9, 3'd3, 23'h03FFFF, 23'h040000, 23'h000000, 5'h03, 1'b1, 8'hF6};
      vecs[2]  = '{4'd2, 16'h8000, 3'd3, 23'h03FFFF, 23'h040000, 23'h000000, 5'h03, 1'b0, 8'hF6};
      vecs[3]  = '{4'd2, 16'h000A, 3'd3, 23'h03FFFF, 23'h040000, 23'h0003FF, 5'h03, 1'b0, 8'hF6};
      vecs[4]  = '{4'd0, 16'h7EE7, 3'd7, 23'h7FFFFF, 23'h000000, 23'h0003FF, 5'h1F, 1'b0, 8'h7E};
      vecs[5]  = '{4'd2, 16'h001F, 3'd7, 23'h7FFFFF, 23'h000000, 23'h7FFFFF, 5'h1F, 1'b0, 8'h7E};
      vecs[6]  = '{4'd0, 16'h0008, 3'd7, 23'h7FFFFF, 23'h000000, 23'h7FFFFF, 5'h1F, 1'b1, 8'h7E};
      vecs[7]  = '{4'd2, 16'h0016, 3'd7, 23'h7FFFFF, 23'h000000, 23'h3FFFFF, 5'h1F, 1'b1, 8'h7E};
      vecs[8]  = '{4'd0, 16'h42C0, 3'd0, 23'h3FFFFF, 23'h400000, 23'h3FFFFF, 5'h10, 1'b1, 8'hFE};
      vecs[9]  = '{4'd5, 16'hFFFF, 3'd0, 23'h3FFFFF, 23'h400000, 23'h3FFFFF, 5'h10, 1'b1, 8'hFE};
      vecs[10] = '{4'd2, 16'h8000, 3'd0, 23'h3FFFFF, 23'h400000, 23'h000000, 5'h10, 1'b0, 8'hFE};
   endtask

   function automatic logic [22:0] maskOf(input int lg);
      if (lg >= ADDR_BITS) return '1;
      return 23'((64'd1 << lg) - 64'd1);
   endfunction

   function automatic logic [22:0] baseOf(input int lg);
      if (lg >= ADDR_BITS) return '0;
      return 23'(64'd1 << lg);
   endfunction

   task automatic modelReset();
      mSel = 0; mGame = 0; mSwitch = 0; mIdle = 0;
      mArgs = '0; mPrg = '0; mChrBase = '0; mChrMask = '0;
      mLaunch = '0; mErr = 1'b0; mCpuRst = 1'b0;
   endtask

   task automatic modelWrite(input logic [3:0] a, input logic [15:0] d);
      int id;
      int lg;
      id = int'(d[4:0]);
      lg = int'(d[9:5]);
      if (a == 4'd0 && !mCpuRst) begin
         if (id >= MAP_CNT) mErr = 1'b1;
         else begin
            mGame = id; mArgs = d[14:10]; mPrg = maskOf(lg); mChrBase = baseOf(lg);
         end
      end else if (a == 4'd1 && !mCpuRst) begin
         mLaunch = d[3:0];
      end else if (a == 4'd2) begin
         if (!mCpuRst) mChrMask = maskOf(int'(d[4:0]));
         if (d[15]) mErr = 1'b0;
      end
   endtask

   task automatic modelFall(input logic [15:0] a, input logic r);
      int  newSel;
      bit  rstH, nmiH, menuH, restH;
      rstH  = mLaunch[1] && a == 16'hFFFC && r;
      nmiH  = mLaunch[3] && a == 16'hFFFA && r;
      menuH = mLaunch[3] && a == 16'hFFFB && r;
      restH = mLaunch[2] && a == 16'hFFEB && r;
      newSel = mSel;
      if (restH)     newSel = mGame;
      else if (rstH) newSel = mGame;
      else if (nmiH) newSel = 0;
      if (rstH)  mLaunch[1] = 1'b0;
      if (menuH) mLaunch[3] = 1'b0;
      if (restH) mLaunch[2] = 1'b0;
      if (mCpuRst) newSel = 0;
      if (newSel != mSel) mSwitch = (mSwitch + 1) % 256;
      mSel = newSel;
   endtask

   function automatic int expSelect();
      if (mLaunch[1] && bus.cpu_addr == 16'hFFFC && bus.cpu_rw) return mGame;
      if (mLaunch[3] && bus.cpu_addr == 16'hFFFA && bus.cpu_rw) return 0;
      return mSel;
   endfunction

   task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      int         es;
      logic [7:0] emr;
      es = expSelect();
      for (int n = 0; n < MAP_CNT; n++) emr[n] = ((n != es) && (n != mGame)) || mCpuRst;
      chk(tag, "select",        32'(selectO),       32'(es));
      chk(tag, "game_select",   32'(gameSelectO),   32'(mGame));
      chk(tag, "mapper_reset",  32'(mapperResetO),  32'(emr));
      chk(tag, "map_args",      32'(mapArgsO),      32'(mArgs));
      chk(tag, "prg_mask",      32'(prgMaskO),      32'(mPrg));
      chk(tag, "chr_base",      32'(chrBaseO),      32'(mChrBase));
      chk(tag, "chr_mask",      32'(chrMaskO),      32'(mChrMask));
      chk(tag, "launcher_ctrl", 32'(launcherCtrlO), 32'(mLaunch));
      chk(tag, "cpu_reset",     32'(cpuResetO),     32'(mCpuRst));
      chk(tag, "cfg_error",     32'(cfgErrorO),     32'(mErr));
      chk(tag, "switch_cnt",    32'(switchCntO),    32'(mSwitch));
   endtask

   // One MCU register write: present data, toggle, let the synchroniser settle
   task automatic applyStimulus(input logic [3:0] a, input logic [15:0] d);
      bus.wr_reg         = d;
      bus.wr_reg_addr    = a;
      bus.wr_reg_changed = ~bus.wr_reg_changed;
      repeat (5) @(posedge clk);
      #1;
      modelWrite(a, d);
      mIdle += 5;
   endtask

   // One CPU access: address held through the M2 high phase and past the fall
   task automatic cpuCycle(input logic [15:0] a, input logic r);
      bus.cpu_addr = a;
      bus.cpu_rw   = r;
      bus.m2       = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("live");
      @(posedge clk);
      #1;
      bus.m2 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      modelFall(a, r);
      bus.cpu_addr = 16'h0000;
      bus.cpu_rw   = 1'b0;
      @(posedge clk);
      #1;
      mIdle = 8;
   endtask

   task automatic randomPhase();
      int          op;
      int          r;
      int          pick;
      logic [15:0] d;
      logic [15:0] a;
      logic        rw;
      for (int i = 0; i < 150; i++) begin
         op = $urandom_range(0, 2);
         if (mIdle > 150) op = 2;
         if (op == 0) begin
            r = $urandom_range(0, 3);
            d = 16'($urandom);
            if (r == 0) d[4:0] = 5'($urandom_range(0, 11));
            applyStimulus(4'(r), d);
         end else begin
            pick = $urandom_range(0, 5);
            case (pick)
               0:       a = 16'hFFFC;
               1:       a = 16'hFFFA;
               2:       a = 16'hFFFB;
               3:       a = 16'hFFEB;
               4:       a = 16'($urandom);
               default: a = 16'hFFFC;
            endcase
            rw = ($urandom_range(0, 3) != 0);
            cpuCycle(a, rw);
         end
         checkOutput("rand");
      end
   endtask

   initial begin
      int savedSwitch;
      int savedErr;

      reset              = 1'b1;
      bus.m2             = 1'b0;
      bus.cpu_addr       = 16'h0000;
      bus.cpu_rw         = 1'b0;
      bus.wr_reg         = 16'h0000;
      bus.wr_reg_addr    = 4'd0;
      bus.wr_reg_changed = 1'b0;
      modelReset();
      loadVectors();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset");
      chk("reset", "mapper_reset_const", 32'(mapperResetO), 32'hFE);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Register decode table
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].regAddr, vecs[i].data);
         chk("vec", "game_select",  32'(gameSelectO),  32'(vecs[i].expGame));
         chk("vec", "prg_mask",     32'(prgMaskO),     32'(vecs[i].expPrg));
         chk("vec", "chr_base",     32'(chrBaseO),     32'(vecs[i].expChrBase));
         chk("vec", "chr_mask",     32'(chrMaskO),     32'(vecs[i].expChrMask));
         chk("vec", "map_args",     32'(mapArgsO),     32'(vecs[i].expArgs));
         chk("vec", "cfg_error",    32'(cfgErrorO),    32'(vecs[i].expErr));
         chk("vec", "mapper_reset", 32'(mapperResetO), 32'(vecs[i].expMapRst));
         chk("vec", "select",       32'(selectO),      32'h0);
      end

      // Launch the game through the reset-vector hijack
      applyStimulus(4'd0, 16'h0E43);
      applyStimulus(4'd1, 16'h0002);
      checkOutput("seqA-pre");
      bus.cpu_addr = 16'hFFFC;
      bus.cpu_rw   = 1'b1;
      #1;
      chk("seqA", "select_live", 32'(selectO), 32'h3);
      cpuCycle(16'hFFFC, 1'b1);
      checkOutput("seqA-post");
      chk("seqA", "select_reg",  32'(selectO),       32'h3);
      chk("seqA", "start_app",   32'(launcherCtrlO), 32'h0);
      chk("seqA", "switch_cnt",  32'(switchCntO),    32'h1);

      // In-game menu via NMI, menu exit, then restore back to the game
      applyStimulus(4'd1, 16'h0008);
      cpuCycle(16'hFFFA, 1'b1);
      checkOutput("seqB-nmi");
      chk("seqB", "select_nmi", 32'(selectO), 32'h0);
      cpuCycle(16'hFFFB, 1'b1);
      checkOutput("seqB-menu");
      chk("seqB", "ingame_menu", 32'(launcherCtrlO), 32'h0);
      chk("seqB", "switch_cnt",  32'(switchCntO),    32'h2);
      applyStimulus(4'd1, 16'h0004);
      cpuCycle(16'hFFEB, 1'b1);
      checkOutput("seqB-restore");
      chk("seqB", "select_restore", 32'(selectO), 32'h3);

      randomPhase();

      // Watchdog: stop M2 and let the idle counter run out
      cpuCycle(16'h0000, 1'b0);
      checkOutput("wd-start");
      repeat (230) @(posedge clk);
      #1;
      checkOutput("wd-before");
      repeat (30) @(posedge clk);
      #1;
      mCpuRst = 1'b1;
      mSel = 0; mGame = 0; mArgs = '0; mPrg = '0; mChrBase = '0; mChrMask = '0; mLaunch = '0;
      checkOutput("wd-active");
      chk("wd", "mapper_reset_all", 32'(mapperResetO), 32'hFF);
      savedSwitch = mSwitch;
      savedErr    = int'(mErr);
      applyStimulus(4'd1, 16'h000F);
      applyStimulus(4'd0, 16'h0E43);
      checkOutput("wd-dropped");
      chk("wd", "launcher_dropped", 32'(launcherCtrlO), 32'h0);
      cpuCycle(16'h0000, 1'b0);
      mCpuRst = 1'b0;
      checkOutput("wd-resume");
      chk("wd", "switch_kept", 32'(switchCntO), 32'(savedSwitch));
      chk("wd", "err_kept",    32'(cfgErrorO),  32'(savedErr));

      // Async reset with a pending start_app
      applyStimulus(4'd0, 16'h0E43);
      applyStimulus(4'd1, 16'h0002);
      checkOutput("mid-pre");
      @(posedge clk);
      #3;
      reset = 1'b1;
      bus.wr_reg_changed = 1'b0;
      #1;
      modelReset();
      checkOutput("mid-reset");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      bus.cpu_addr = 16'hFFFC;
      bus.cpu_rw   = 1'b1;
      #1;
      chk("mid", "no_hijack_live", 32'(selectO), 32'h0);
      cpuCycle(16'hFFFC, 1'b1);
      checkOutput("mid-post");
      chk("mid", "switch_cnt", 32'(switchCntO), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
